// File: rtl/hc_sr04_ranger.sv
// HC-SR04 ranger: fires a trigger pulse every PERIOD_US ticks, times the echo in us, converts it to mm.
// Echo edges are seen 3 Clk after the pin moves; no backpressure, results are one-cycle pulses.
module hc_sr04_ranger #(
  parameter int TRIG_US    = 10,
  parameter int PERIOD_US  = 60000,
  parameter int TIMEOUT_US = 30000,
  parameter int CNT_W      = 16
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        us_tick,
  input  logic        en,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] dist_mm,
  output logic        dist_valid,
  output logic        timeout,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, CALC, HOLDOFF} state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_US - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_US - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_US - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state;
  logic             echo_m, echo_s, echo_d;
  logic             echo_rise, echo_fall;
  logic [CNT_W-1:0] trig_cnt, wait_cnt, echo_cnt, period_cnt;
  logic [31:0]      prod;

  assign echo_rise = echo_s & ~echo_d;
  assign echo_fall = ~echo_s & echo_d;
  assign busy      = (state != IDLE);

  // 11239 / 2^16 ~= 0.1715 mm per us of round-trip echo at 343 m/s
  assign prod = 32'(echo_cnt) * 32'd11239;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      echo_m     <= 1'b0;
      echo_s     <= 1'b0;
      echo_d     <= 1'b0;
      trig_cnt   <= '0;
      wait_cnt   <= '0;
      echo_cnt   <= '0;
      period_cnt <= '0;
      trig       <= 1'b0;
      dist_mm    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      echo_m     <= echo;
      echo_s     <= echo_m;
      echo_d     <= echo_s;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;

      if (state != IDLE && us_tick && period_cnt != PERIOD_LAST)
        period_cnt <= period_cnt + CNT_ONE;

      case (state)
        IDLE: begin
          if (en && us_tick) begin
            state      <= TRIG;
            trig_cnt   <= '0;
            period_cnt <= '0;
          end
        end
        TRIG: begin
          trig <= 1'b1;
          if (us_tick) begin
            if (trig_cnt == TRIG_LAST) begin
              state    <= WAIT_RISE;
              trig     <= 1'b0;
              wait_cnt <= '0;
            end else begin
              trig_cnt <= trig_cnt + CNT_ONE;
            end
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            state    <= MEASURE;
            echo_cnt <= '0;
          end else if (us_tick) begin
            if (wait_cnt == TIMEOUT_LAST) begin
              state   <= HOLDOFF;
              timeout <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + CNT_ONE;
            end
          end
        end
        MEASURE: begin
          // a falling edge in the same cycle as the width limit still yields a distance
          if (echo_fall) begin
            state <= CALC;
          end else if (us_tick) begin
            if (echo_cnt == TIMEOUT_LAST) begin
              state   <= HOLDOFF;
              timeout <= 1'b1;
            end else begin
              echo_cnt <= echo_cnt + CNT_ONE;
            end
          end
        end
        CALC: begin
          dist_mm    <= 16'(prod >> 16);
          dist_valid <= 1'b1;
          state      <= HOLDOFF;
        end
        HOLDOFF: begin
          // a sensor still holding echo high must not be re-triggered
          if (us_tick && period_cnt == PERIOD_LAST && !echo_s) begin
            if (en) begin
              state      <= TRIG;
              trig_cnt   <= '0;
              period_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hc_sr04_ranger.md
Name: hc_sr04_ranger

Overview:
- Consumes the 1 us tick from the system clock divider.
- Drives the HC-SR04 trigger pin and times the returned echo pulse in microseconds.
- Converts the echo width to distance in millimetres and repeats the measurement periodically while enabled.
- Sits between the clock divider and the display/UART consumers of distance.

Parameters:
- TRIG_US, 10, trigger pulse width in us ticks.
- PERIOD_US, 60000, us ticks from one trigger rise to the next.
- TIMEOUT_US, 30000, max us ticks waiting for echo rise, and max echo width.
- CNT_W, 16, width of the us counters; must hold PERIOD_US.

Ports:
- Clk  input  1  system clock, 50 MHz.
- Rst  input  1  synchronous reset, active-high.
- us_tick  input  1  one-Clk-cycle pulse every 1 us.
- en  input  1  level; enables periodic ranging.
- echo  input  1  asynchronous echo pin from sensor.
- trig  output  1  trigger pin to sensor.
- dist_mm  output  16  last valid distance, mm.
- dist_valid  output  1  one-cycle pulse when dist_mm updates.
- timeout  output  1  one-cycle pulse on a failed measurement.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: one clock; reset is synchronous and active-high, sampled on rising Clk.
  - Reset values: trig=0, dist_mm=0, dist_valid=0, timeout=0, busy=0.
  - State goes to IDLE; all counters and synchronizer flops go to 0.
  - Reset mid-operation aborts immediately; trig drops on the next edge.
- echo synchronization and edges:
  - echo passes through 2 flops to give echo_s.
  - Edges are detected on echo_s against its 1-cycle delayed copy.
  - Edge latency is 3 Clk cycles, negligible versus 1 us.
- All timing counters advance only on cycles where us_tick=1.
- FSM states:
  - IDLE: if en=1 and us_tick=1, go to TRIG; clear trig_cnt and period_cnt.
  - TRIG:
    - trig=1 (registered; rises the cycle after entry).
    - trig_cnt++ per tick.
    - On the tick where trig_cnt==TRIG_US-1, go to WAIT_RISE; trig=0 next cycle.
    - Trigger high time is therefore exactly TRIG_US us (±1 Clk).
  - WAIT_RISE:
    - On echo_s rising edge, go to MEASURE with echo_cnt=0.
    - Otherwise wait_cnt++ per tick; at wait_cnt==TIMEOUT_US-1, pulse timeout and go to HOLDOFF.
  - MEASURE:
    - echo_cnt++ per tick.
    - On echo_s falling edge, go to CALC.
    - At echo_cnt==TIMEOUT_US-1 with echo still high, pulse timeout and go to HOLDOFF.
    - If a falling edge and the timeout occur in the same cycle, the falling edge wins: CALC, no timeout.
  - CALC (1 cycle):
    - dist_mm <= (echo_cnt * 16'd11239) >> 16, using a 32-bit product and truncation.
    - This gives mm at 343 m/s round-trip.
    - dist_valid=1 in the cycle dist_mm takes its new value.
    - Then go to HOLDOFF.
  - HOLDOFF:
    - Leave when period_cnt==PERIOD_US-1 on a tick AND echo_s==0.
    - Exit goes to TRIG if en=1, else to IDLE.
    - A sensor still driving echo high blocks the next trigger.
- period_cnt:
  - Counts ticks from TRIG entry and saturates at PERIOD_US-1.
  - Runs through all states except IDLE.
- dist_mm holds its value between updates; a timeout does not change it.
- en deasserted mid-measurement lets the current cycle complete; the block returns to IDLE at the HOLDOFF exit.
- dist_valid and timeout are never both high, and never high for more than 1 cycle.
- us_tick high for consecutive cycles is illegal input; behaviour is undefined.

Test Plan:
- Reset with en=1 → trig low, then a trig pulse of 10 us with rise ≤1 tick after reset release; busy=1.
- Echo high 1000 us after trigger → dist_valid pulse; dist_mm=171; timeout stays 0.
- Echo high 5830 us → dist_mm=999; next trig rise 60000 us after previous rise.
- No echo → timeout pulse 30000 us after trig fall; dist_mm keeps prior value; next trigger still at 60000 us.
- Echo stuck high past 30000 us → timeout at width 30000; next trig withheld until echo low, then on next tick after period expiry.
- en dropped during MEASURE with echo 2000 us → dist_mm=342, valid pulse, busy falls at period end, no new trig; Rst asserted during TRIG → trig=0 next cycle, all outputs at reset values.
